// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (data width, bit timing, receive FIFO defaults).
package uart_pkg;
  localparam int UART_DATA_W            = 8;
  localparam int UART_CLKS_PER_BIT      = 217;
  localparam int UART_RX_FIFO_DEPTH     = 16;
  localparam int UART_RX_TIMEOUT_CYCLES = 4 * 10 * UART_CLKS_PER_BIT;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side strobe plus register-block read/status signals of the RX FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH
);
  localparam int LW = $clog2(DEPTH + 1);
  logic                   in_valid;
  logic [UART_DATA_W-1:0] in_data;
  logic                   pop;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic [LW-1:0]          level;
  logic [LW-1:0]          thresh;
  logic                   overrun;
  logic                   ovr_clr;
  logic                   irq;
  modport master (
    output in_valid, in_data, pop, thresh, ovr_clr,
    input  rd_data, empty, full, level, overrun, irq
  );
  modport slave (
    input  in_valid, in_data, pop, thresh, ovr_clr,
    output rd_data, empty, full, level, overrun, irq
  );
endinterface

// File: rtl/uart_rx_idle_timer.sv
// uart_rx_idle_timer: counts idle cycles of a non-empty FIFO and raises a sticky timeout flag.
module uart_rx_idle_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = UART_RX_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic clr,
  output logic timeout_flag
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt          <= restart ? '0 : (cnt == LAST) ? cnt : cnt + 1'b1;
      timeout_flag <= !clr && (timeout_flag || cnt == LAST);
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO with level/overrun status and threshold interrupt.
// Optional idle-timeout interrupt source enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = UART_RX_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = UART_RX_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, lvl;
  logic empty, full, do_push, do_pop, drop, ovr_q, irq_q, timeout_flag;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign lvl     = wr_ptr - rd_ptr;
  assign do_pop  = bus.pop && !empty;
  // a pop on a full FIFO frees the slot for a same-cycle push
  assign do_push = bus.in_valid && (!full || do_pop);
  assign drop    = bus.in_valid && !do_push;
  assign bus.rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.level   = LW'(lvl);
  assign bus.overrun = ovr_q;
  assign bus.irq     = irq_q;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovr_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      ovr_q <= drop ? 1'b1 : bus.ovr_clr ? 1'b0 : ovr_q;
      irq_q <= (bus.thresh != '0 && LW'(lvl) >= bus.thresh) || ovr_q || timeout_flag;
    end
  end
`ifdef UART_RX_TIMEOUT_EN
  uart_rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (do_push || do_pop || empty),
    .clr          (do_pop),
    .timeout_flag (timeout_flag)
  );
`else
  assign timeout_flag = 1'b0;
`endif
endmodule
